// File: rtl/bsg_rr_merge_pkg.sv
// Shared constants and types for the 2-lane round-robin merge.
// Lane indices are an enum so the head pointer reads as a lane, not a bare bit.
package bsg_rr_merge_pkg;

  localparam int lanes_lp = 2;

  typedef enum logic {
    e_lane0 = 1'b0,
    e_lane1 = 1'b1
  } lane_e;

  function automatic lane_e next_lane(input lane_e cur);
    return (cur == e_lane0) ? e_lane1 : e_lane0;
  endfunction

endpackage

// File: rtl/bsg_rr_merge_lane_fifo.sv
// Per-lane buffer: ready/valid enqueue side, valid/yumi dequeue side.
// Only the pointers, count and liveness flag are reset; the storage array is not.
module bsg_rr_merge_lane_fifo
  import bsg_rr_merge_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_count;
  logic [cnt_w_lp-1:0] w_count_next;
  logic                r_live;
  logic                w_full;
  logic                w_empty;
  logic                w_enq;
  logic                w_deq;

  // Ready comes from registered state only, so a full FIFO refuses input
  // even in the cycle it is being popped.
  assign w_full  = (r_count == full_cnt_lp);
  assign w_empty = (r_count == '0);
  assign ready_o = r_live & ~w_full;
  assign v_o     = ~w_empty;
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + cnt_w_lp'(1);
      2'b01:   w_count_next = r_count - cnt_w_lp'(1);
      default: w_count_next = r_count;
    endcase
  end

  // r_live holds ready low until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_count <= w_count_next;
      if (w_enq) begin
        r_wptr <= r_wptr + ptr_w_lp'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + ptr_w_lp'(1);
      end
    end
  end

  a_els_pow2: assert property (@(posedge clk_i)
    (els_p >= 2) && ((els_p & (els_p - 1)) == 0));

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);

endmodule

// File: rtl/bsg_round_robin_2_to_1_merge.sv
// Re-serialises two buffered lanes onto one stream in strict lane0/lane1 order,
// restoring the word order of a stream that was swizzled across two lanes.
module bsg_round_robin_2_to_1_merge
  import bsg_rr_merge_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [lanes_lp*width_p-1:0] data_i,
  input  logic [lanes_lp-1:0]         v_i,
  output logic [lanes_lp-1:0]         ready_o,
  output logic [width_p-1:0]          data_o,
  output logic                        v_o,
  input  logic                        ready_i
);

  logic [width_p-1:0]  w_lane_data [lanes_lp];
  logic [lanes_lp-1:0] w_lane_v;
  logic [lanes_lp-1:0] w_lane_yumi;
  lane_e               r_head;
  lane_e               w_head_next;
  logic                w_head_idx;
  logic                w_fire;

  for (genvar k = 0; k < lanes_lp; k++) begin : g_lane
    bsg_rr_merge_lane_fifo #(
      .width_p (width_p),
      .els_p   (els_p)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (data_i[k*width_p +: width_p]),
      .v_i       (v_i[k]),
      .ready_o   (ready_o[k]),
      .data_o    (w_lane_data[k]),
      .v_o       (w_lane_v[k]),
      .yumi_i    (w_lane_yumi[k])
    );

    assign w_lane_yumi[k] = w_fire & (w_head_idx == 1'(k));

    a_hold_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (v_i[k] && !ready_o[k]) |=> v_i[k]);
  end

  // Output only ever looks at the head lane; an empty head stalls the stream
  // even when the other lane has data.
  assign w_head_idx = r_head;
  assign v_o        = w_lane_v[w_head_idx];
  assign data_o     = w_lane_data[w_head_idx];
  assign w_fire     = v_o & ready_i;

  always_comb begin
    w_head_next = r_head;
    if (w_fire) begin
      w_head_next = next_lane(r_head);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head <= e_lane0;
    end else begin
      r_head <= w_head_next;
    end
  end

endmodule
